// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: collects operand A, operand B and opcode bytes from a UART
// receiver, evaluates an 8-bit ALU operation and hands the result to a UART
// transmitter with a one-cycle start pulse, then waits for the transmitter's
// completion strobe before accepting the next frame.
module uart_alu_bridge #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_done_data,
    input  logic               i_done_tx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    // Shift amounts split into a low field that indexes a bit position and an
    // upper field that, when non-zero, means "shift everything out".
    // This relies on NB_DATA being a power of two.
    localparam int SHW = $clog2(NB_DATA);

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_t;

    rx_state_t          r_rx_state;
    tx_state_t          r_tx_state;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    logic               r_alu_valid;
    logic               r_busy;
    logic [NB_DATA-1:0] r_data;
    logic               r_tx_start;

    logic               w_tx_done;
    logic               w_shift_big;
    logic [SHW-1:0]     w_shamt;
    logic [NB_DATA-1:0] w_alu_result;

    // Transmitter acknowledged only while a result is actually in flight.
    assign w_tx_done   = (r_tx_state == TX_WAIT) && i_done_tx;
    assign w_shift_big = |r_b[NB_DATA-1:SHW];
    assign w_shamt     = r_b[SHW-1:0];

    // Combinational ALU over the registered operands; results wrap naturally.
    always_comb begin
        w_alu_result = '0;
        case (r_op)
            OP_ADD: w_alu_result = r_a + r_b;
            OP_SUB: w_alu_result = r_a - r_b;
            OP_AND: w_alu_result = r_a & r_b;
            OP_OR:  w_alu_result = r_a | r_b;
            OP_XOR: w_alu_result = r_a ^ r_b;
            OP_NOR: w_alu_result = ~(r_a | r_b);
            OP_SRA: begin
                if (w_shift_big)
                    w_alu_result = {NB_DATA{r_a[NB_DATA-1]}};
                else
                    w_alu_result = $signed(r_a) >>> w_shamt;
            end
            OP_SRL: begin
                if (w_shift_big)
                    w_alu_result = '0;
                else
                    w_alu_result = r_a >> w_shamt;
            end
            default: w_alu_result = '0;
        endcase
    end

    // RX sequencer: capture A, B, opcode in order; opcode launches the ALU and
    // raises busy, which blocks further bytes until the transmitter is done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_state  <= GET_A;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_alu_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_alu_valid <= 1'b0;
            if (w_tx_done)
                r_busy <= 1'b0;
            if (i_done_data && !r_busy) begin
                case (r_rx_state)
                    GET_A: begin
                        r_a        <= i_data;
                        r_rx_state <= GET_B;
                    end
                    GET_B: begin
                        r_b        <= i_data;
                        r_rx_state <= GET_OP;
                    end
                    GET_OP: begin
                        r_op        <= i_data[NB_OP-1:0];
                        r_alu_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_rx_state  <= GET_A;
                    end
                    default: r_rx_state <= GET_A;
                endcase
            end
        end
    end

    // TX sequencer: latch the result and pulse start once, then hold o_data
    // until the transmitter reports completion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_data     <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_alu_valid) begin
                        r_data     <= w_alu_result;
                        r_tx_start <= 1'b1;
                        r_tx_state <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (i_done_tx)
                        r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign o_data     = r_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Scoreboard bench for uart_alu_bridge: stimulus pushes expected result bytes
// (with the cycle their start pulse is due) and a monitor pops them whenever
// the bridge pulses o_tx_start.
module tb_uart_alu_bridge;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       done_data;
    logic       done_tx;
    logic [7:0] dout;
    logic       tx_start;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [7:0] last_exp = 8'h00;

    uart_alu_bridge #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (din),
        .i_done_data (done_data),
        .i_done_tx   (done_tx),
        .o_data      (dout),
        .o_tx_start  (tx_start),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference ALU written from the operation table with integer arithmetic.
    function automatic logic [7:0] ref_alu(input int a, input int b, input int op_byte);
        int op;
        int sa;
        int r;
        op = op_byte % 64;
        sa = (a >= 128) ? a - 256 : a;
        case (op)
            32: r = a + b;
            34: r = a - b + 256;
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = 255 - (a | b);
            3:  r = (b >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> b);
            2:  r = (b >= 8) ? 0 : (a / (1 << b));
            default: r = 0;
        endcase
        return 8'(r % 256 + ((r < 0) ? 256 : 0));
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every start pulse must match the oldest expectation, on time.
    initial begin
        logic prev_start;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                if (prev_start) begin
                    check("start_pulse_width", 2, 1);
                end else if (sb_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result_data", dout, e.data);
                    check("start_latency", cyc, e.cyc);
                    $display("tx data=0x%02h exp=0x%02h cyc=%0d", dout, e.data, cyc);
                end
            end
            prev_start = rst ? 1'b0 : tx_start;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        din       = b;
        done_data = 1'b1;
        @(negedge clk);
        done_data = 1'b0;
    endtask

    // Send one frame to an idle bridge and expect 'exp' two cycles after the
    // opcode strobe; leaves the bridge busy waiting for done_tx.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [7:0] exp);
        exp_t e;
        send_byte(a);
        send_byte(b);
        @(negedge clk);
        din       = op;
        done_data = 1'b1;
        e.data    = exp;
        e.cyc     = cyc + 2;
        sb_q.push_back(e);
        @(negedge clk);
        done_data = 1'b0;
        check("busy_after_op", busy, 1);
        repeat (3) @(negedge clk);
        check("data_held", dout, exp);
        last_exp = exp;
    endtask

    // Pulse done_tx; optionally strobe a junk byte on the same edge, which the
    // bridge must still ignore.
    task automatic ack(input bit with_junk);
        @(negedge clk);
        done_tx = 1'b1;
        if (with_junk) begin
            din       = 8'h55;
            done_data = 1'b1;
        end
        @(negedge clk);
        done_tx   = 1'b0;
        done_data = 1'b0;
        check("busy_after_ack", busy, 0);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] ra, rb, rop, rexp;
        exp_t       e;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        rst = 1'b1; din = 8'h00; done_data = 1'b0; done_tx = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_data", dout, 0);
        check("rst_start", tx_start, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Basic frames
        send_frame(8'h04, 8'h02, 8'h20, 8'h06);
        ack(1'b0);
        send_frame(8'h06, 8'h03, 8'h22, 8'h03);
        ack(1'b0);

        // Opcode sweep, A=0xF0 B=0x02
        send_frame(8'hF0, 8'h02, 8'h20, 8'hF2); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h22, 8'hEE); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h24, 8'h00); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h25, 8'hF2); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h26, 8'hF2); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h27, 8'h0D); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h03, 8'hFC); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h02, 8'h3C); ack(1'b0);
        send_frame(8'hF0, 8'h02, 8'h3F, 8'h00); ack(1'b0);

        // Wrap and shift boundaries; upper opcode bits ignored on the last
        send_frame(8'h7F, 8'h01, 8'h20, 8'h80); ack(1'b0);
        send_frame(8'h80, 8'h09, 8'h03, 8'hFF); ack(1'b0);
        send_frame(8'h80, 8'h09, 8'h02, 8'h00); ack(1'b0);
        send_frame(8'h80, 8'h07, 8'hC3, 8'hFF); ack(1'b0);

        // Bytes while busy are dropped; junk byte on the ack edge too
        send_frame(8'h10, 8'h20, 8'h26, 8'h30);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
        repeat (3) @(negedge clk);
        check("busy_hold_data", dout, 8'h30);
        check("busy_still", busy, 1);
        ack(1'b1);
        send_frame(8'h09, 8'h05, 8'h22, 8'h04); ack(1'b0);

        // A strobe held for three edges carries three bytes
        @(negedge clk);
        done_data = 1'b1; din = 8'h21;
        @(negedge clk); din = 8'h12;
        @(negedge clk); din = 8'h20;
        e.data = 8'h33; e.cyc = cyc + 2; sb_q.push_back(e);
        @(negedge clk); done_data = 1'b0;
        repeat (3) @(negedge clk);
        check("held_strobe_data", dout, 8'h33);
        ack(1'b0);

        // Reset after A and B discards the partial frame
        send_byte(8'h44); send_byte(8'h55);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("midrst_data", dout, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h01, 8'h01, 8'h20, 8'h02); ack(1'b0);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            rop = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                              : {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
            rexp = ref_alu(int'(ra), int'(rb), int'(rop));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_frame(ra, rb, rop, rexp);
            ack($urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
